res_reader: RTL and testbench
=============================

Name: res_reader

Overview:
- Reader end of the CPU_shell result-readout interface.
- Drives `ressel` and captures the 16-bit `{resdt_h,resdt_l}` for all four result registers into a snapshot bank, then shows one selected register on the four DE0 7-segment digits.
- A scan is triggered by the rising edge of `endseq` or by a manual request.
- Displayed data always comes from one complete, coherent scan.

Parameters:
- SETTLE_CYCLES, 2, wait cycles between changing `ressel` and sampling `resdt`; 0 is legal.
- SCAN_PERIOD, 5_000_000, auto-scan interval in clocks (used only with RES_AUTO_SCAN_EN).

Ports:
- clock  input  1  system clock
- reset_N  input  1  asynchronous active-low reset
- endseq  input  1  CPU_shell end-of-sequence level; a rising edge triggers a scan
- snap_req  input  1  one-cycle manual scan request
- view_sel  input  2  register index to display (DE0 switches)
- resdt_h  input  8  result data high byte from CPU_shell
- resdt_l  input  8  result data low byte from CPU_shell
- ressel  output  2  result register select to CPU_shell
- busy  output  1  high while a scan is in progress
- snap_done  output  1  one-cycle pulse when a scan commits
- hex3..hex0  output  7 each  active-low segments {g..a}; hex3 = `resdt_h[7:4]`, hex0 = `resdt_l[3:0]`

Behaviour:
- **Reset (async, `reset_N`=0):**
  - State IDLE, idx=0, pending=0, `endseq_d`=0.
  - Work bank and shadow bank cleared to 0.
  - `busy`=0, `snap_done`=0, `ressel`=0.
  - hex3..hex0 = 7'b1000000 ("0").
  - Reset mid-scan aborts the scan; the shadow bank is cleared, not committed.
- **Trigger:** `trig` = (`endseq` & ~`endseq_d`) | `snap_req`, with `endseq_d` registered each clock.
- **State machine** (one state per clock unless noted):
  - IDLE: `ressel` = `view_sel`. On `trig`: idx=0, go to DRIVE.
  - DRIVE: `ressel` = idx. Load settle counter with SETTLE_CYCLES. Go to SETTLE, or to CAPTURE if SETTLE_CYCLES=0.
  - SETTLE: decrement the counter. Go to CAPTURE when it reaches 1.
  - CAPTURE: work[idx] <= `{resdt_h,resdt_l}`. If idx==3 go to DONE, else idx+1 and go to DRIVE.
  - DONE: shadow <= work (all four words in one clock). `snap_done`=1 for this cycle only. Go to DRIVE with idx=0 if pending (clear pending), else go to IDLE.
- **`ressel` hold:** stable from DRIVE through CAPTURE of the same idx.
- **Latency:**
  - Trigger seen in IDLE at cycle T means DRIVE at T+1.
  - `snap_done` at T+1+4*(SETTLE_CYCLES+2); T+17 with the default SETTLE_CYCLES=2.
- **`busy`:** 1 in every state except IDLE.
- **Trigger while busy:** sets pending. Several triggers merge into one extra scan. A trigger arriving in DONE also sets pending.
- **Simultaneous trigger sources:** `endseq` edge and `snap_req` in the same cycle count as one trigger.
- **Display path:**
  - Registered, one clock after a change of `view_sel` or of shadow.
  - Shows shadow[`view_sel`] only, never the work bank or live `resdt`.
  - Digits are hex 0-F with standard segment patterns.

Optional Feature:
- Macro `RES_AUTO_SCAN_EN`.
- Defined:
  - A free-running counter counts 0..SCAN_PERIOD-1 and ORs a one-cycle trigger into `trig` on wrap.
  - The counter runs regardless of state; wraps during a scan set pending.
- Undefined: no counter logic. Only `endseq` edges and `snap_req` trigger scans.

Decomposition:
- Package `res_reader_pkg`:
  - state enum (IDLE, DRIVE, SETTLE, CAPTURE, DONE)
  - RES_COUNT=4
  - ressel index constants; RESSEL_AREG=2'd1
  - 7-segment blank/zero constants
- Sub-module `hex7seg`: purely combinational 4-bit to 7-segment active-low decoder, instantiated four times.

Test Plan:
1. Reset, then `resdt` model returns 16'h1000+`ressel`, `view_sel`=1, pulse `snap_req` → `ressel` steps 0,1,2,3, each held 4 cycles. `snap_done` at T+17. hex3..hex0 show "1001".
2. `endseq` 0→1 held high for 50 cycles → exactly one scan, one `snap_done`. `endseq` staying high causes no retrigger.
3. Second `snap_req` at DRIVE of idx 2 plus `endseq` edge at idx 3 → exactly one back-to-back extra scan (DONE→DRIVE); two `snap_done` pulses total.
4. Change model data to 16'hBEEF for idx 1 mid-scan after its CAPTURE → display keeps the old value until DONE, then shows "BEEF" only after the next full scan.
5. Assert `reset_N`=0 during SETTLE of idx 2 → outputs go to reset values immediately; `busy`=0, display "0000", no `snap_done`.
6. With `RES_AUTO_SCAN_EN`, SCAN_PERIOD=40 → a scan starts every 40 cycles with no external triggers; `view_sel`=3 shows shadow[3].

Source files
------------

// File: rtl/res_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : res_reader_pkg
// Brief   : Shared constants for the CPU_shell result reader.
// Rev     : 1.0  initial release
// ============================================================================
package res_reader_pkg;

    localparam int RES_COUNT = 4;

    typedef logic [2:0]  state_t;
    typedef logic [15:0] res_word_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DRIVE   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_CAPTURE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [1:0] RESSEL_XREG = 2'd0;
    localparam logic [1:0] RESSEL_AREG = 2'd1;
    localparam logic [1:0] RESSEL_BREG = 2'd2;
    localparam logic [1:0] RESSEL_CREG = 2'd3;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module  : hex7seg
// Brief   : Combinational 4-bit to active-low 7-segment decoder {g..a}.
// Rev     : 1.0  initial release
// ============================================================================
module hex7seg
    import res_reader_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_ZERO;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/res_reader.sv
`default_nettype none
// ============================================================================
// Module  : res_reader
// Brief   : Scans all four CPU_shell result registers into a coherent snapshot
//           and shows one of them on four hex digits. Optional free-running
//           auto-scan is built in when RES_AUTO_SCAN_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
module res_reader
    import res_reader_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int SCAN_PERIOD   = 5_000_000
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       endseq,
    input  logic       snap_req,
    input  logic [1:0] view_sel,
    input  logic [7:0] resdt_h,
    input  logic [7:0] resdt_l,
    output logic [1:0] ressel,
    output logic       busy,
    output logic       snap_done,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             endseq_q;
    logic [1:0]       ressel_q, ressel_d;
    res_word_t        work_q   [RES_COUNT];
    res_word_t        work_d   [RES_COUNT];
    res_word_t        shadow_q [RES_COUNT];
    res_word_t        shadow_d [RES_COUNT];
    logic [6:0]       hex_q    [4];
    logic [6:0]       hex_d    [4];
    logic [6:0]       w_seg    [4];
    res_word_t        w_view_word;
    logic             w_auto_trig;
    logic             w_trig;

`ifdef RES_AUTO_SCAN_EN
    localparam int PER_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

    logic [PER_W-1:0] scan_cnt_q, scan_cnt_d;

    assign w_auto_trig = (scan_cnt_q == PER_W'(SCAN_PERIOD - 1));
    assign scan_cnt_d  = w_auto_trig ? '0 : scan_cnt_q + PER_W'(1);

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) scan_cnt_q <= '0;
        else          scan_cnt_q <= scan_cnt_d;
    end
`else
    // The period only matters when the auto-scan counter is built in.
    assign w_auto_trig = 1'b0 & (SCAN_PERIOD != 0);
`endif

    assign w_trig = (endseq & ~endseq_q) | snap_req | w_auto_trig;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        work_d    = work_q;
        shadow_d  = shadow_q;
        case (state_q)
            ST_IDLE: begin
                if (w_trig) begin
                    idx_d   = RESSEL_XREG;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                pending_d = pending_q | w_trig;
                cnt_d     = CNT_W'(SETTLE_CYCLES);
                state_d   = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
                pending_d = pending_q | w_trig;
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                pending_d     = pending_q | w_trig;
                work_d[idx_q] = {resdt_h, resdt_l};
                if (idx_q == RESSEL_CREG) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                shadow_d = work_q;
                // A trigger landing in DONE merges with any pending request.
                if (pending_q | w_trig) begin
                    pending_d = 1'b0;
                    idx_d     = RESSEL_XREG;
                    state_d   = ST_DRIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ressel_d = (state_d == ST_IDLE) ? view_sel : idx_d;
    end

    assign w_view_word = shadow_q[view_sel];

    for (genvar g = 0; g < 4; g++) begin : g_digit
        hex7seg u_dec (
            .nibble (w_view_word[4*g +: 4]),
            .seg    (w_seg[g])
        );
    end

    always_comb hex_d = w_seg;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_q   <= ST_IDLE;
            idx_q     <= RESSEL_XREG;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            endseq_q  <= 1'b0;
            ressel_q  <= RESSEL_XREG;
            for (int i = 0; i < RES_COUNT; i++) begin
                work_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) hex_q[i] <= SEG_ZERO;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            endseq_q  <= endseq;
            ressel_q  <= ressel_d;
            work_q    <= work_d;
            shadow_q  <= shadow_d;
            hex_q     <= hex_d;
        end
    end

    assign ressel    = ressel_q;
    assign busy      = (state_q != ST_IDLE);
    assign snap_done = (state_q == ST_DONE);
    assign hex3      = hex_q[3];
    assign hex2      = hex_q[2];
    assign hex1      = hex_q[1];
    assign hex0      = hex_q[0];

endmodule
`default_nettype wire

// File: tb/tb_res_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_res_reader
// Brief   : Self-checking bench for res_reader; RES_AUTO_SCAN_EN selects the
//           auto-scan scenario instead of the manual-trigger scenarios.
// Rev     : 1.0  initial release
// ============================================================================
module tb_res_reader;

    localparam int SETTLE = 2;
    localparam int SLOT   = SETTLE + 2;
    localparam int LAT    = 1 + 4 * SLOT;
`ifdef RES_AUTO_SCAN_EN
    localparam int PERIOD = 40;
`else
    localparam int PERIOD = 5_000_000;
`endif

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clock = 1'b0;
    logic       reset_N, endseq, snap_req;
    logic [1:0] view_sel;
    logic [7:0] resdt_h, resdt_l;
    logic [1:0] ressel;
    logic       busy, snap_done;
    logic [6:0] hex3, hex2, hex1, hex0;

    logic [15:0] model_data [4];
    logic [15:0] exp_shadow [4];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    // CPU_shell model: result register selected by ressel
    assign {resdt_h, resdt_l} = model_data[ressel];

    res_reader #(.SETTLE_CYCLES(SETTLE), .SCAN_PERIOD(PERIOD)) dut (
        .clock(clock), .reset_N(reset_N), .endseq(endseq), .snap_req(snap_req),
        .view_sel(view_sel), .resdt_h(resdt_h), .resdt_l(resdt_l),
        .ressel(ressel), .busy(busy), .snap_done(snap_done),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0)
    );

    function automatic logic [27:0] disp_of(input logic [15:0] w);
        return {SEG_TAB[w[15:12]], SEG_TAB[w[11:8]], SEG_TAB[w[7:4]], SEG_TAB[w[3:0]]};
    endfunction

    function automatic logic [27:0] disp_now();
        return {hex3, hex2, hex1, hex0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) model_data[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        reset_N = 1'b1; endseq = 1'b0; snap_req = 1'b0;
        view_sel = 2'($urandom);
        randomize_data();
        #2 reset_N = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        tick(); tick();
        n_checks++; if (snap_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", snap_done); else n_pass++;
        n_checks++; if (ressel !== 2'd0) $display("FAIL reset_ressel: got %0d expected 0", ressel); else n_pass++;
        n_checks++; if (disp_now() !== disp_of(16'h0)) $display("FAIL reset_disp: got %h expected %h", disp_now(), disp_of(16'h0)); else n_pass++;
        for (int i = 0; i < 4; i++) exp_shadow[i] = 16'h0;
        reset_N = 1'b1;
        tick(); tick();
        n_checks++; if (ressel !== view_sel) $display("FAIL idle_ressel: got %0d expected %0d", ressel, view_sel); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else n_pass++;
    endtask

    task automatic test_snap_scan();
        logic [27:0] old_disp;
        for (int i = 0; i < 4; i++) model_data[i] = 16'h1000 + 16'(i);
        view_sel = 2'd1;
        tick(); tick();
        old_disp = disp_of(exp_shadow[1]);
        snap_req = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            snap_req = 1'b0;
            if (c < LAT) begin
                n_checks++; if (ressel !== 2'((c - 1) / SLOT)) $display("FAIL scan_ressel c=%0d: got %0d expected %0d", c, ressel, (c - 1) / SLOT); else n_pass++;
                n_checks++; if (busy !== 1'b1) $display("FAIL scan_busy c=%0d: got %b expected 1", c, busy); else n_pass++;
            end
            if (c <= LAT) begin
                n_checks++; if (snap_done !== (c == LAT)) $display("FAIL scan_done c=%0d: got %b expected %b", c, snap_done, (c == LAT)); else n_pass++;
            end
            if (c == LAT + 1) begin
                n_checks++; if (disp_now() !== old_disp) $display("FAIL scan_disp_lag: got %h expected %h", disp_now(), old_disp); else n_pass++;
            end
        end
        for (int i = 0; i < 4; i++) exp_shadow[i] = model_data[i];
        n_checks++; if (disp_now() !== disp_of(16'h1001)) $display("FAIL scan_disp_1001: got %h expected %h", disp_now(), disp_of(16'h1001)); else n_pass++;
    endtask

    task automatic test_endseq_level();
        int pulses = 0;
        int first  = -1;
        randomize_data();
        endseq = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 50) endseq = 1'b0;
            if (snap_done) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        for (int i = 0; i < 4; i++) exp_shadow[i] = model_data[i];
        n_checks++; if (pulses !== 1) $display("FAIL endseq_pulses: got %0d expected 1", pulses); else n_pass++;
        n_checks++; if (first !== LAT) $display("FAIL endseq_latency: got %0d expected %0d", first, LAT); else n_pass++;
        view_sel = 2'($urandom);
        tick();
        n_checks++; if (disp_now() !== disp_of(exp_shadow[view_sel])) $display("FAIL endseq_disp: got %h expected %h", disp_now(), disp_of(exp_shadow[view_sel])); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int t1 = -1;
        int t2 = -1;
        randomize_data();
        snap_req = 1'b1;
        for (int c = 1; c <= 2 * LAT + 5; c++) begin
            tick();
            snap_req = (c == 1 + 2 * SLOT);
            endseq   = (c >= 1 + 3 * SLOT);
            if (snap_done) begin
                pulses++;
                if (t1 < 0) t1 = c; else if (t2 < 0) t2 = c;
            end
            if (c == LAT + 1) begin
                n_checks++; if ({busy, ressel} !== 3'b100) $display("FAIL b2b_redrive: got busy=%b ressel=%0d expected busy=1 ressel=0", busy, ressel); else n_pass++;
            end
        end
        endseq = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) exp_shadow[i] = model_data[i];
        n_checks++; if (pulses !== 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses); else n_pass++;
        n_checks++; if (t1 !== LAT || t2 !== 2 * LAT) $display("FAIL b2b_timing: got %0d,%0d expected %0d,%0d", t1, t2, LAT, 2 * LAT); else n_pass++;
    endtask

    task automatic test_mid_scan_change();
        logic [15:0] a1;
        int bad = 0;
        randomize_data();
        if (model_data[1] == 16'hBEEF) model_data[1] = 16'h0BEE;
        a1 = model_data[1];
        view_sel = 2'd1;
        snap_req = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin tick(); snap_req = 1'b0; end
        n_checks++; if (disp_now() !== disp_of(a1)) $display("FAIL mid_warm_disp: got %h expected %h", disp_now(), disp_of(a1)); else n_pass++;
        snap_req = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            snap_req = 1'b0;
            if (c == 2 * SLOT + 1) model_data[1] = 16'hBEEF;
            if (disp_now() !== disp_of(a1)) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL mid_disp_hold: got %0d bad cycles expected 0", bad); else n_pass++;
        snap_req = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            tick();
            snap_req = 1'b0;
            if (c == LAT + 1) begin
                n_checks++; if (disp_now() !== disp_of(a1)) $display("FAIL mid_disp_prev: got %h expected %h", disp_now(), disp_of(a1)); else n_pass++;
            end
        end
        for (int i = 0; i < 4; i++) exp_shadow[i] = model_data[i];
        n_checks++; if (disp_now() !== disp_of(16'hBEEF)) $display("FAIL mid_disp_beef: got %h expected %h", disp_now(), disp_of(16'hBEEF)); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        int pulses = 0;
        int bad = 0;
        view_sel = 2'd1;
        snap_req = 1'b1;
        for (int c = 1; c <= 2 * SLOT + 3; c++) begin tick(); snap_req = 1'b0; end
        n_checks++; if ({busy, ressel} !== 3'b110) $display("FAIL rst_pre: got busy=%b ressel=%0d expected busy=1 ressel=2", busy, ressel); else n_pass++;
        reset_N = 1'b0;
        #1;
        n_checks++; if ({busy, snap_done, ressel} !== 4'b0000) $display("FAIL rst_async_ctl: got %b expected 0000", {busy, snap_done, ressel}); else n_pass++;
        n_checks++; if (disp_now() !== disp_of(16'h0)) $display("FAIL rst_async_disp: got %h expected %h", disp_now(), disp_of(16'h0)); else n_pass++;
        tick(); tick();
        reset_N = 1'b1;
        for (int i = 0; i < 4; i++) exp_shadow[i] = 16'h0;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (snap_done) pulses++;
            if (disp_now() !== disp_of(16'h0)) bad++;
        end
        n_checks++; if (pulses !== 0) $display("FAIL rst_no_done: got %0d expected 0", pulses); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL rst_disp_zero: got %0d bad cycles expected 0", bad); else n_pass++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int kind = int'($urandom_range(0, 2));
            int seen = -1;
            randomize_data();
            view_sel = 2'($urandom);
            snap_req = (kind != 1);
            endseq   = (kind != 0);
            for (int c = 1; c <= LAT + 10 && seen < 0; c++) begin
                tick();
                snap_req = 1'b0;
                if (snap_done) seen = c;
            end
            n_checks++; if (seen !== LAT) $display("FAIL rand_latency it=%0d: got %0d expected %0d", it, seen, LAT); else n_pass++;
            for (int i = 0; i < 4; i++) exp_shadow[i] = model_data[i];
            endseq = 1'b0;
            tick(); tick();
            n_checks++; if (disp_now() !== disp_of(exp_shadow[view_sel])) $display("FAIL rand_disp it=%0d: got %h expected %h", it, disp_now(), disp_of(exp_shadow[view_sel])); else n_pass++;
            view_sel = 2'($urandom);
            tick();
            n_checks++; if (disp_now() !== disp_of(exp_shadow[view_sel])) $display("FAIL rand_view it=%0d: got %h expected %h", it, disp_now(), disp_of(exp_shadow[view_sel])); else n_pass++;
        end
    endtask

    task automatic test_auto_scan();
        int times [$];
        randomize_data();
        view_sel = 2'd3;
        for (int c = 1; c <= 5 * PERIOD + 5; c++) begin
            tick();
            if (snap_done) times.push_back(c);
        end
        n_checks++; if (times.size() < 4) $display("FAIL auto_count: got %0d expected >=4", times.size()); else n_pass++;
        for (int k = 1; k < times.size(); k++) begin
            n_checks++; if (times[k] - times[k-1] !== PERIOD) $display("FAIL auto_period k=%0d: got %0d expected %0d", k, times[k] - times[k-1], PERIOD); else n_pass++;
        end
        n_checks++; if (disp_now() !== disp_of(model_data[3])) $display("FAIL auto_disp: got %h expected %h", disp_now(), disp_of(model_data[3])); else n_pass++;
    endtask

    initial begin
        test_reset();
`ifdef RES_AUTO_SCAN_EN
        test_auto_scan();
`else
        test_snap_scan();
        test_endseq_level();
        test_back_to_back();
        test_mid_scan_change();
        test_reset_mid_scan();
        test_random();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
